// File: rtl/stopwatch_controller_if.sv
// rtl/stopwatch_controller_if.sv - control pulses in, display word and status out

interface stopwatch_controller_if;
  logic        start_stop_i;
  logic        lap_i;
  logic        clear_i;
  logic [23:0] bcd_data_out;
  logic        dp_out;
  logic        lap_active_out;
  logic        wrap_out;

  // Pulse source and display consumer
  modport master (
    output start_stop_i, lap_i, clear_i,
    input  bcd_data_out, dp_out, lap_active_out, wrap_out
  );

  // Stopwatch controller side
  modport slave (
    input  start_stop_i, lap_i, clear_i,
    output bcd_data_out, dp_out, lap_active_out, wrap_out
  );
endinterface

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/lap FSM, centisecond time base and MM:SS.CC BCD counter

module stopwatch_controller #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stopwatch_controller_if.slave sw
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP_RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [23:0]   time_q;
  logic [23:0]   lap_q;
  logic          wrap_q;
  logic          do_clear;
  logic          do_capture;
  logic          counting;
  logic          tick;
  logic [24:0]   time_inc;

  // One BCD step across all six digits; bit 24 is the carry out of min tens.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        c;
    logic [3:0]  lim;
    logic [3:0]  d;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      d   = t[4*i +: 4];
      if (c) begin
        if (d == lim) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  assign counting = (state_q == RUN) || (state_q == LAP_RUN);
  assign tick     = counting && (pre_q == PRE_MAX);
  assign time_inc = bcd_inc(time_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state with clear > start_stop > lap among pulses the state accepts
  always_comb begin
    state_d    = state_q;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sw.start_stop_i) state_d = RUN;
      end
      RUN: begin
        if (sw.start_stop_i) begin
          state_d = PAUSE;
        end else if (sw.lap_i) begin
          state_d    = LAP_RUN;
          do_capture = 1'b1;
        end
      end
      LAP_RUN: begin
        if (sw.start_stop_i)  state_d = PAUSE;
        else if (sw.lap_i)    state_d = RUN;
      end
      PAUSE: begin
        if (sw.clear_i) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else if (sw.start_stop_i) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler: runs while counting, holds in PAUSE so partial periods resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           pre_q <= '0;
    else if (state_q == IDLE || do_clear) pre_q <= '0;
    else if (tick)                        pre_q <= '0;
    else if (counting)                    pre_q <= pre_q + PW'(1);
  end

  // Live time: cascaded BCD increment on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        time_q <= '0;
    else if (do_clear) time_q <= '0;
    else if (tick)     time_q <= time_inc[23:0];
  end

  // Lap snapshot takes the pre-edge live time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lap_q <= '0;
    else if (do_clear)   lap_q <= '0;
    else if (do_capture) lap_q <= time_q;
  end

  // Single-cycle pulse after the 59:59.99 -> 00:00.00 rollover
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= tick && time_inc[24];
  end

  assign sw.bcd_data_out   = (state_q == LAP_RUN) ? lap_q : time_q;
  assign sw.lap_active_out = (state_q == LAP_RUN);
  assign sw.dp_out         = counting;
  assign sw.wrap_out       = wrap_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - directed checks of stopwatch_controller at TICK_DIV 10 and 1

module tb_stopwatch_controller;

  logic clk  = 1'b0;
  logic fclk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;
  int   wraps  = 0;
  int   viol   = 0;
  logic mon_en = 1'b0;

  stopwatch_controller_if sa ();
  stopwatch_controller_if sb ();

  stopwatch_controller #(.CLK_HZ(1000), .TICK_HZ(100)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .sw    (sa)
  );

  stopwatch_controller #(.CLK_HZ(100), .TICK_HZ(100)) dut_b (
    .clk   (fclk),
    .rst_n (rst_b),
    .sw    (sb)
  );

  always #10 clk  = ~clk;
  always #1  fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_a(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_b(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic pulse_a(input logic ss, input logic lp, input logic cl);
    sa.start_stop_i = ss;
    sa.lap_i        = lp;
    sa.clear_i      = cl;
    @(negedge clk);
    sa.start_stop_i = 1'b0;
    sa.lap_i        = 1'b0;
    sa.clear_i      = 1'b0;
  endtask

  task automatic pulse_b_start();
    sb.start_stop_i = 1'b1;
    @(negedge fclk);
    sb.start_stop_i = 1'b0;
  endtask

  // Digit range and wrap pulse monitor for the fast instance
  always @(negedge fclk) begin
    if (mon_en) begin
      if (sb.wrap_out) wraps <= wraps + 1;
      if (sb.bcd_data_out[3:0]   > 4'd9 || sb.bcd_data_out[7:4]   > 4'd9 ||
          sb.bcd_data_out[11:8]  > 4'd9 || sb.bcd_data_out[15:12] > 4'd5 ||
          sb.bcd_data_out[19:16] > 4'd9 || sb.bcd_data_out[23:20] > 4'd5)
        viol <= viol + 1;
    end
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    sa.start_stop_i = 1'b0; sa.lap_i = 1'b0; sa.clear_i = 1'b0;
    sb.start_stop_i = 1'b0; sb.lap_i = 1'b0; sb.clear_i = 1'b0;
    wait_a(3);
    chk("rst_bcd",  {8'h0, sa.bcd_data_out}, 32'h0);
    chk("rst_dp",   {31'h0, sa.dp_out}, 32'h0);
    chk("rst_lap",  {31'h0, sa.lap_active_out}, 32'h0);
    chk("rst_wrap", {31'h0, sa.wrap_out}, 32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    wait_a(1);

    // ---- TICK_DIV = 10 ----
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("start_dp", {31'h0, sa.dp_out}, 32'h1);
    wait_a(9);
    chk("edge9",    {8'h0, sa.bcd_data_out}, 32'h000000);
    wait_a(1);
    chk("edge10",   {8'h0, sa.bcd_data_out}, 32'h000001);
    wait_a(990);
    chk("inc100",   {8'h0, sa.bcd_data_out}, 32'h000100);
    chk("inc100_dp", {31'h0, sa.dp_out}, 32'h1);

    wait_a(3);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("pause_dp", {31'h0, sa.dp_out}, 32'h0);
    wait_a(50);
    chk("pause_hold", {8'h0, sa.bcd_data_out}, 32'h000100);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("resume_dp", {31'h0, sa.dp_out}, 32'h1);
    wait_a(5);
    chk("resume5", {8'h0, sa.bcd_data_out}, 32'h000100);
    wait_a(1);
    chk("resume6", {8'h0, sa.bcd_data_out}, 32'h000101);

    pulse_a(1'b0, 1'b0, 1'b1);
    chk("run_clr_dp",  {31'h0, sa.dp_out}, 32'h1);
    chk("run_clr_bcd", {8'h0, sa.bcd_data_out}, 32'h000101);

    wait_a(219);
    chk("at123", {8'h0, sa.bcd_data_out}, 32'h000123);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("lap_active", {31'h0, sa.lap_active_out}, 32'h1);
    chk("lap_dp",     {31'h0, sa.dp_out}, 32'h1);
    chk("lap_frozen0", {8'h0, sa.bcd_data_out}, 32'h000123);
    wait_a(30);
    chk("lap_frozen30", {8'h0, sa.bcd_data_out}, 32'h000123);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk("lap2_active", {31'h0, sa.lap_active_out}, 32'h0);
    chk("lap2_live",   {8'h0, sa.bcd_data_out}, 32'h000126);

    pulse_a(1'b1, 1'b1, 1'b0);
    chk("ss_lap_dp",  {31'h0, sa.dp_out}, 32'h0);
    chk("ss_lap_la",  {31'h0, sa.lap_active_out}, 32'h0);
    chk("ss_lap_bcd", {8'h0, sa.bcd_data_out}, 32'h000126);

    pulse_a(1'b1, 1'b0, 1'b1);
    chk("clr_dp",  {31'h0, sa.dp_out}, 32'h0);
    chk("clr_bcd", {8'h0, sa.bcd_data_out}, 32'h000000);
    chk("clr_la",  {31'h0, sa.lap_active_out}, 32'h0);
    pulse_a(1'b0, 1'b1, 1'b1);
    chk("idle_ign_dp", {31'h0, sa.dp_out}, 32'h0);
    chk("idle_ign_la", {31'h0, sa.lap_active_out}, 32'h0);
    pulse_a(1'b1, 1'b0, 1'b0);
    wait_a(9);
    chk("clr_pre9",  {8'h0, sa.bcd_data_out}, 32'h000000);
    wait_a(1);
    chk("clr_pre10", {8'h0, sa.bcd_data_out}, 32'h000001);

    // ---- TICK_DIV = 1 ----
    @(negedge fclk);
    pulse_b_start();
    wait_b(4217);
    chk("b_4217", {8'h0, sb.bcd_data_out}, 32'h004217);
    @(posedge fclk);
    rst_b = 1'b0;
    @(negedge fclk);
    chk("b_rst_bcd",  {8'h0, sb.bcd_data_out}, 32'h0);
    chk("b_rst_dp",   {31'h0, sb.dp_out}, 32'h0);
    chk("b_rst_wrap", {31'h0, sb.wrap_out}, 32'h0);
    @(negedge fclk);
    rst_b = 1'b1;
    wait_b(2);
    chk("b_post_rst", {8'h0, sb.bcd_data_out}, 32'h0);
    mon_en = 1'b1;
    pulse_b_start();
    chk("b_start0", {8'h0, sb.bcd_data_out}, 32'h0);
    wait_b(1);
    chk("b_start1", {8'h0, sb.bcd_data_out}, 32'h000001);
    wait_b(5999);
    chk("b_6000", {8'h0, sb.bcd_data_out}, 32'h010000);
    wait_b(353999);
    chk("b_595999", {8'h0, sb.bcd_data_out}, 32'h595999);
    chk("b_prewrap", {31'h0, sb.wrap_out}, 32'h0);
    wait_b(1);
    chk("b_wrap_bcd", {8'h0, sb.bcd_data_out}, 32'h000000);
    chk("b_wrap_hi",  {31'h0, sb.wrap_out}, 32'h1);
    wait_b(1);
    chk("b_wrap_lo",  {31'h0, sb.wrap_out}, 32'h0);
    chk("b_after",    {8'h0, sb.bcd_data_out}, 32'h000001);
    mon_en = 1'b0;
    wait_b(1);
    chk("b_wrap_cnt", wraps, 32'd1);
    chk("b_digits",   viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the 6-digit stopwatch display path. It converts debounced start/stop, lap and clear pulses into a run/pause/lap state machine and generates a centisecond tick from the system clock. It maintains the MM:SS.CC time as a cascaded BCD counter and presents either the live time or a frozen lap time as a 24-bit BCD word for the display controller.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- TICK_HZ, 100, time-base increment rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_stop_i  in  1  single-cycle pulse, already debounced and synchronised
- lap_i  in  1  single-cycle pulse, already debounced and synchronised
- clear_i  in  1  single-cycle pulse, already debounced and synchronised
- bcd_data_out  out  24  displayed time: [3:0] cs ones, [7:4] cs tens, [11:8] sec ones, [15:12] sec tens, [19:16] min ones, [23:20] min tens
- dp_out  out  1  1 while counting (RUN or LAP_RUN)
- lap_active_out  out  1  1 while display shows frozen lap time
- wrap_out  out  1  one-cycle pulse on 59:59.99 → 00:00.00

## Operation
- Registers: state, prescaler (width max(1,$clog2(TICK_DIV))), time_bcd[23:0], lap_bcd[23:0], wrap pulse.
- States: IDLE, RUN, PAUSE, LAP_RUN.
- IDLE: start_stop → RUN; lap, clear ignored.
- RUN: start_stop → PAUSE; lap → LAP_RUN and lap_bcd ← time_bcd; clear ignored.
- LAP_RUN: counting continues; lap → RUN (display live again); start_stop → PAUSE; clear ignored.
- PAUSE: start_stop → RUN; clear → IDLE with time_bcd, lap_bcd, prescaler zeroed; lap ignored.
- Input priority, same cycle: clear > start_stop > lap, considering only inputs valid in the current state. The losing pulse is dropped, not queued.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN/LAP_RUN.
  - Holds its value in PAUSE, so partial periods resume.
  - Forced to 0 in IDLE.
  - tick = counting && prescaler == TICK_DIV-1; on tick the prescaler returns to 0.
- BCD cascade on tick:
  - cs ones 0–9; carry → cs tens 0–9; carry → sec ones 0–9; carry → sec tens 0–5; carry → min ones 0–9; carry → min tens 0–5.
  - Each digit wraps to 0 when it carries.
  - Full carry-out sets wrap_out for exactly one cycle, and all digits read 0.
- Lap capture samples the pre-edge time_bcd; a tick on the same edge still increments time_bcd.
- bcd_data_out = lap_bcd in LAP_RUN, else time_bcd. It is a register-fed mux with no combinational path from inputs.
- lap_active_out = (state == LAP_RUN).
- dp_out = (state == RUN || state == LAP_RUN).

## Timing
- Reset, asynchronous: state IDLE, prescaler 0, time_bcd 0, lap_bcd 0, bcd_data_out 24'h000000, dp_out 0, lap_active_out 0, wrap_out 0.
- Input pulse sampled at edge N: new state visible after edge N; outputs settle in the same cycle.
- From IDLE, start at edge N: first increment at edge N+TICK_DIV. Thereafter one increment every TICK_DIV cycles while counting.
- Pause at edge N after k counting cycles of the current period; resume at edge M: next increment at edge M+(TICK_DIV−k).
- wrap_out asserts in the cycle after the wrapping edge and deasserts one cycle later.
- Reset asserted mid-operation: immediate return to reset values, with no pending increment or capture.
- TICK_DIV = 1: increment on every counting cycle; prescaler stays 0.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10); reset, start at edge 0 → first increment at edge 10; after 100 increments bcd_data_out = 24'h000100; dp_out=1.
- TICK_DIV=1; run 6000 cycles → 24'h010000. Run 360000 cycles total → 24'h000000 with a single wrap_out pulse. Sec tens never exceeds 5, cs digits never exceed 9.
- TICK_DIV=10; start, pause after 4 counting cycles, idle 50 cycles, resume → next increment exactly 6 cycles after resume; value unchanged during pause.
- Run to 24'h000123, lap → bcd_data_out frozen at 24'h000123 with lap_active_out=1 while time_bcd advances. Second lap → live value shown.
- In RUN, clear → ignored. Pause then clear → IDLE, all outputs 0. Same-cycle start_stop+lap in RUN → PAUSE, lap_bcd unchanged.
- Assert rst_n low mid-RUN at 24'h004217, coincident with a tick → all outputs reset values immediately; after release, start restarts from 24'h000000.
